// File: rtl/mem_arbiter_ctrl.sv
// mem_arbiter_ctrl: round-robin servicer of CHANNELS request/response FIFO pairs onto one internal memory.
// Latency: grant (IDLE) -> rd_en +1 -> capture +2 -> memory access +3 -> wr_en +4; one request per 5 cycles.
// Backpressure: a channel is granted only if its request FIFO is non-empty and its response FIFO is not full.
//
// Ports:
//   clk, reset (async, active-high)
//   read_ctr_pack / data_in_pack / empty_flag_pack   : request FIFO side, channel i at slice i
//   write_ctr_pack / data_out_pack / full_flag_pack  : response FIFO side, channel i at slice i
//   busy (FSM not idle), served_count (responses written, wraps at 2^32)
// Optional feature macro: MEM_ARB_RANGE_CHECK_EN -- addresses >= MEM_DEPTH do not write and
// answer all-ones data; without it the address wraps to its low MEM_AW bits.
module mem_arbiter_ctrl #(
    parameter int CHANNELS       = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 31,
    parameter int TID_WIDTH      = 16,
    parameter int MEM_DEPTH      = 1024,
    parameter int MEM_AW         = $clog2(MEM_DEPTH),
    parameter int DP_DATA_WIDTH  = TID_WIDTH + 1 + ADDR_WIDTH + DATA_WIDTH,
    parameter int VPI_DATA_WIDTH = TID_WIDTH + DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    output logic [CHANNELS-1:0]                  read_ctr_pack,
    input  logic [DP_DATA_WIDTH*CHANNELS-1:0]    data_in_pack,
    input  logic [CHANNELS-1:0]                  empty_flag_pack,
    output logic [CHANNELS-1:0]                  write_ctr_pack,
    output logic [VPI_DATA_WIDTH*CHANNELS-1:0]   data_out_pack,
    input  logic [CHANNELS-1:0]                  full_flag_pack,
    output logic                                 busy,
    output logic [31:0]                          served_count
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_POP  = 3'd1,
        S_CAPT = 3'd2,
        S_ACC  = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                     state_q, state_d;
    // grant_q doubles as the round-robin pointer: it holds the last granted channel.
    logic [CW-1:0]              grant_q, grant_d;
    logic [DP_DATA_WIDTH-1:0]   req_q;
    logic [VPI_DATA_WIDTH-1:0]  data_out_q [CHANNELS];
    logic [31:0]                served_q;
    logic [DATA_WIDTH-1:0]      mem [MEM_DEPTH];

    logic [CHANNELS-1:0]        elig;
    logic                       any_elig;
    logic [CW-1:0]              pick;

    // Request word layout {tid, wr_flag, addr, data}
    logic [TID_WIDTH-1:0]       req_tid;
    logic                       req_wr;
    logic [ADDR_WIDTH-1:0]      req_addr;
    logic [DATA_WIDTH-1:0]      req_data;
    logic [MEM_AW-1:0]          mem_addr;
    logic                       mem_we;
    logic [DATA_WIDTH-1:0]      resp_data;
    logic                       unused_addr_bits;

    assign req_tid  = req_q[DP_DATA_WIDTH-1 -: TID_WIDTH];
    assign req_wr   = req_q[ADDR_WIDTH + DATA_WIDTH];
    assign req_addr = req_q[DATA_WIDTH +: ADDR_WIDTH];
    assign req_data = req_q[DATA_WIDTH-1:0];
    assign mem_addr = req_addr[MEM_AW-1:0];
    assign unused_addr_bits = ^req_addr;

    assign elig = ~empty_flag_pack & ~full_flag_pack;

    // Search from grant_q+1 upward (mod CHANNELS). Iterating k downward lets the
    // nearest eligible channel be the last assignment, so it wins.
    always_comb begin
        int idx;
        any_elig = 1'b0;
        pick     = grant_q;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = (int'(grant_q) + k) % CHANNELS;
            if (elig[idx]) begin
                any_elig = 1'b1;
                pick     = CW'(idx);
            end
        end
    end

`ifdef MEM_ARB_RANGE_CHECK_EN
    logic addr_oor;
    assign addr_oor  = (req_addr >= ADDR_WIDTH'(MEM_DEPTH));
    assign mem_we    = (state_q == S_ACC) && req_wr && !addr_oor;
    assign resp_data = addr_oor ? {DATA_WIDTH{1'b1}} : (req_wr ? req_data : mem[mem_addr]);
`else
    assign mem_we    = (state_q == S_ACC) && req_wr;
    assign resp_data = req_wr ? req_data : mem[mem_addr];
`endif

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        read_ctr_pack  = '0;
        write_ctr_pack = '0;
        case (state_q)
            S_IDLE: begin
                if (any_elig) begin
                    grant_d = pick;
                    state_d = S_POP;
                end
            end
            S_POP: begin
                read_ctr_pack[grant_q] = 1'b1;
                state_d = S_CAPT;
            end
            S_CAPT: state_d = S_ACC;
            S_ACC:  state_d = S_RESP;
            S_RESP: begin
                write_ctr_pack[grant_q] = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            grant_q  <= CW'(CHANNELS - 1);
            req_q    <= '0;
            served_q <= '0;
            for (int i = 0; i < CHANNELS; i++) data_out_q[i] <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            // FIFO output is valid the cycle after rd_en, i.e. during CAPT.
            if (state_q == S_CAPT) req_q <= data_in_pack[grant_q*DP_DATA_WIDTH +: DP_DATA_WIDTH];
            // Response word is staged at the end of ACC so it is valid alongside wr_en in RESP.
            if (state_q == S_ACC)  data_out_q[grant_q] <= {req_tid, resp_data};
            if (state_q == S_RESP) served_q <= served_q + 32'd1;
        end
    end

    // Memory has no reset; contents persist across controller resets.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= req_data;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_out
        assign data_out_pack[i*VPI_DATA_WIDTH +: VPI_DATA_WIDTH] = data_out_q[i];
    end

    assign busy         = (state_q != S_IDLE);
    assign served_count = served_q;

endmodule

// File: tb/tb_mem_arbiter_ctrl.sv
// tb_mem_arbiter_ctrl: directed bench for mem_arbiter_ctrl with 4 channels and FIFO models.
// Stimulus and checks step at posedge+1; FIFO models and the monitor act on the negedge.
// Request FIFO data is presented only during the cycle after rd_en, poisoned otherwise.
module tb_mem_arbiter_ctrl;
    localparam int CH  = 4;
    localparam int DPW = 16 + 1 + 31 + 32;
    localparam int VPW = 16 + 32;
    localparam logic [DPW-1:0] POISON = {DPW{1'b1}};

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [CH-1:0]     read_ctr_pack;
    logic [DPW*CH-1:0] data_in_pack = '0;
    logic [CH-1:0]     empty_flag_pack = '1;
    logic [CH-1:0]     write_ctr_pack;
    logic [VPW*CH-1:0] data_out_pack;
    logic [CH-1:0]     full_flag_pack = '0;
    logic              busy;
    logic [31:0]       served_count;

    mem_arbiter_ctrl #(.CHANNELS(CH)) dut (
        .clk(clk), .reset(reset),
        .read_ctr_pack(read_ctr_pack), .data_in_pack(data_in_pack),
        .empty_flag_pack(empty_flag_pack), .write_ctr_pack(write_ctr_pack),
        .data_out_pack(data_out_pack), .full_flag_pack(full_flag_pack),
        .busy(busy), .served_count(served_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [DPW-1:0] req_q0[$], req_q1[$], req_q2[$], req_q3[$];
    logic [DPW-1:0] pend [CH];
    logic [CH-1:0]  pend_vld = '0;

    int             cyc = 0;
    int             last_rd_cyc = 0;
    int             grant_log[$];
    int             resp_ch[$];
    logic [VPW-1:0] resp_dat[$];
    int             lat_log[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DPW-1:0] mk_req(input int tid, input bit wr, input int addr, input logic [31:0] dat);
        logic [15:0] t;
        logic [30:0] a;
        t = 16'(tid);
        a = 31'(addr);
        return {t, wr, a, dat};
    endfunction

    function automatic int qsize(input int ch);
        case (ch)
            0: return req_q0.size();
            1: return req_q1.size();
            2: return req_q2.size();
            default: return req_q3.size();
        endcase
    endfunction

    function automatic logic [DPW-1:0] qpop(input int ch);
        case (ch)
            0: return req_q0.pop_front();
            1: return req_q1.pop_front();
            2: return req_q2.pop_front();
            default: return req_q3.pop_front();
        endcase
    endfunction

    task automatic push(input int ch, input logic [DPW-1:0] w);
        case (ch)
            0: req_q0.push_back(w);
            1: req_q1.push_back(w);
            2: req_q2.push_back(w);
            default: req_q3.push_back(w);
        endcase
    endtask

    // Request FIFO models and output monitor.
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int i = 0; i < CH; i++) begin
            if (pend_vld[i]) begin
                data_in_pack[i*DPW +: DPW] = pend[i];
                pend_vld[i] = 1'b0;
            end else begin
                data_in_pack[i*DPW +: DPW] = POISON;
            end
            if (read_ctr_pack[i]) begin
                grant_log.push_back(i);
                last_rd_cyc = cyc;
                if (qsize(i) > 0) begin
                    pend[i] = qpop(i);
                    pend_vld[i] = 1'b1;
                end
            end
            if (write_ctr_pack[i]) begin
                resp_ch.push_back(i);
                resp_dat.push_back(data_out_pack[i*VPW +: VPW]);
                lat_log.push_back(cyc - last_rd_cyc);
            end
            empty_flag_pack[i] = (qsize(i) == 0);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        grant_log.delete();
        resp_ch.delete();
        resp_dat.delete();
        lat_log.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        clear_logs();
        step(1);
    endtask

    task automatic wait_served(input string tag, input int target, input int budget);
        int n = 0;
        while (served_count != 32'(target) && n < budget) begin
            step(1);
            n++;
        end
        chk(tag, 64'(served_count), 64'(target));
    endtask

    initial begin
        int cnt [CH];
        int rd_seen;

        // Reset state
        step(1);
        chk("rst_rd_en", 64'(read_ctr_pack), 64'h0);
        chk("rst_wr_en", 64'(write_ctr_pack), 64'h0);
        chk("rst_dout", 64'(data_out_pack[63:0]), 64'h0);
        chk("rst_dout_hi", 64'(data_out_pack[VPW*CH-1:64]), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_served", 64'(served_count), 64'h0);
        reset = 1'b0;
        clear_logs();
        step(20);
        chk("idle_no_rd", 64'(grant_log.size()), 64'h0);
        chk("idle_busy", 64'(busy), 64'h0);

        // Single channel write then read of the same address
        push(0, mk_req(5, 1'b1, 3, 32'hDEADBEEF));
        push(0, mk_req(6, 1'b0, 3, 32'h0));
        rd_seen = 0;
        for (int n = 0; n < 10 && grant_log.size() == 0; n++) step(1);
        chk("single_busy", 64'(busy), 64'h1);
        wait_served("single_served", 2, 40);
        chk("single_nresp", 64'(resp_ch.size()), 64'd2);
        if (resp_ch.size() == 2) begin
            chk("single_ch_a", 64'(resp_ch[0]), 64'd0);
            chk("single_wr_resp", 64'(resp_dat[0]), 64'h0005_DEADBEEF);
            chk("single_ch_b", 64'(resp_ch[1]), 64'd0);
            chk("single_rd_resp", 64'(resp_dat[1]), 64'h0006_DEADBEEF);
            chk("single_lat_a", 64'(lat_log[0]), 64'd3);
            chk("single_lat_b", 64'(lat_log[1]), 64'd3);
        end
        step(2);
        chk("single_idle", 64'(busy), 64'h0);

        // Fairness: all four channels loaded with two reads each
        do_reset();
        for (int j = 0; j < 2; j++)
            for (int i = 0; i < CH; i++)
                push(i, mk_req(16 + i*2 + j, 1'b0, 3, 32'h0));
        wait_served("fair_served", 8, 200);
        chk("fair_ngrant", 64'(grant_log.size()), 64'd8);
        if (grant_log.size() == 8)
            for (int k = 0; k < 8; k++)
                chk($sformatf("fair_order%0d", k), 64'(grant_log[k]), 64'(k % CH));
        for (int i = 0; i < CH; i++) cnt[i] = 0;
        foreach (resp_ch[k]) cnt[resp_ch[k]]++;
        for (int i = 0; i < CH; i++) chk($sformatf("fair_cnt%0d", i), 64'(cnt[i]), 64'd2);
        if (resp_dat.size() > 0) chk("fair_first_resp", 64'(resp_dat[0]), 64'h0010_DEADBEEF);

        // Backpressure: ch1 response FIFO full
        do_reset();
        full_flag_pack = 4'b0010;
        push(0, mk_req(32, 1'b0, 3, 32'h0));
        push(0, mk_req(33, 1'b0, 3, 32'h0));
        push(1, mk_req(34, 1'b0, 3, 32'h0));
        wait_served("bp_ch0_served", 2, 60);
        step(15);
        chk("bp_still2", 64'(served_count), 64'd2);
        chk("bp_ngrant", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() == 2) begin
            chk("bp_g0", 64'(grant_log[0]), 64'd0);
            chk("bp_g1", 64'(grant_log[1]), 64'd0);
        end
        full_flag_pack = 4'b0000;
        wait_served("bp_ch1_served", 3, 40);
        if (resp_ch.size() == 3) begin
            chk("bp_ch1", 64'(resp_ch[2]), 64'd1);
            chk("bp_ch1_dat", 64'(resp_dat[2]), 64'h0022_DEADBEEF);
        end

        // Address 1024: out of range with the check, aliases to 0 without it
        do_reset();
        push(2, mk_req(8, 1'b1, 0, 32'h11111111));
        push(2, mk_req(9, 1'b1, 1024, 32'h7));
        push(2, mk_req(10, 1'b0, 0, 32'h0));
        wait_served("range_served", 3, 80);
        if (resp_dat.size() == 3) begin
            chk("range_w0", 64'(resp_dat[0]), 64'h0008_11111111);
`ifdef MEM_ARB_RANGE_CHECK_EN
            chk("range_oor_wr", 64'(resp_dat[1]), 64'h0009_FFFFFFFF);
            chk("range_rd0", 64'(resp_dat[2]), 64'h000A_11111111);
`else
            chk("range_alias_wr", 64'(resp_dat[1]), 64'h0009_00000007);
            chk("range_rd0", 64'(resp_dat[2]), 64'h000A_00000007);
`endif
        end

        // Reset asserted while the FSM is in ACC
        do_reset();
        push(3, mk_req(3, 1'b1, 5, 32'h0000ABCD));
        for (int n = 0; n < 10 && grant_log.size() == 0; n++) step(1);
        chk("mid_popped", 64'(grant_log.size()), 64'd1);
        step(1);
        chk("mid_in_acc_busy", 64'(busy), 64'h1);
        reset = 1'b1;
        #1;
        chk("mid_busy", 64'(busy), 64'h0);
        chk("mid_wr_en", 64'(write_ctr_pack), 64'h0);
        step(2);
        reset = 1'b0;
        step(10);
        chk("mid_no_resp", 64'(resp_ch.size()), 64'd0);
        chk("mid_served", 64'(served_count), 64'd0);
        push(3, mk_req(4, 1'b0, 3, 32'h0));
        wait_served("mid_next_served", 1, 40);
        if (resp_ch.size() == 1) begin
            chk("mid_next_ch", 64'(resp_ch[0]), 64'd3);
            chk("mid_next_dat", 64'(resp_dat[0]), 64'h0004_DEADBEEF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: sim time exceeded");
        $fatal(1, "timeout");
    end

endmodule
